// File: rtl/width_conv_sched.sv
// Word-to-byte sequencing controller for the 32/16/8-to-8-bit width converter.
// Takes one wide word per input handshake, latches its width mode, and emits
// the valid bytes LSB first on an 8-bit valid/ready stream with word markers.
// A new word can be taken on the last-byte cycle, so consecutive words run at
// full byte rate with no idle cycle between them.
module width_conv_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic             out_eof,
  output logic             busy,
  output logic             mode_err,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic [1:0] MODE_8  = 2'b00;
  localparam logic [1:0] MODE_16 = 2'b01;
  localparam logic [1:0] MODE_ILL = 2'b11;

  // Last byte index of a word for a given (legal) width mode.
  function automatic logic [1:0] last_idx(input logic [1:0] m);
    case (m)
      MODE_8:  return 2'd0;
      MODE_16: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [31:0]      hold_q, hold_d;
  logic [1:0]       nb_q, nb_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             mode_err_q, mode_err_d;

  logic mode_ok;
  logic last_byte;
  logic in_xfer;
  logic out_xfer;

  // Handshake qualifiers and the combinational input-ready.
  always_comb begin
    mode_ok   = (mode != MODE_ILL);
    last_byte = (state_q == SEND) && (idx_q == nb_q);
    in_ready  = !reset && mode_ok &&
                ((state_q == IDLE) || (last_byte && out_ready));
    in_xfer   = in_valid && in_ready;
    out_xfer  = out_valid && out_ready;
  end

  // Byte-stream outputs are pure functions of the held word and byte index,
  // so they stay stable for as long as the sink stalls.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_sof   = 1'b0;
    out_eof   = 1'b0;
    if (state_q == SEND) begin
      out_valid = 1'b1;
      out_data  = hold_q[8*idx_q +: 8];
      out_sof   = (idx_q == 2'd0);
      out_eof   = (idx_q == nb_q);
    end
  end

  // Next-state logic: word load, byte advance, word completion and error flag.
  always_comb begin
    // NOTE: every signal written here is given its hold value first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    hold_d     = hold_q;
    nb_d       = nb_q;
    idx_d      = idx_q;
    word_cnt_d = word_cnt_q;
    mode_err_d = mode_err_q || (in_valid && !mode_ok);

    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          hold_d  = in_data;
          nb_d    = last_idx(mode);
          idx_d   = 2'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_xfer) begin
          if (idx_q != nb_q) begin
            idx_d = idx_q + 2'd1;
          end else begin
            if (word_cnt_q != {CNT_W{1'b1}}) begin
              word_cnt_d = word_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (in_xfer) begin
              // Back-to-back: the next word replaces this one with no gap.
              hold_d  = in_data;
              nb_d    = last_idx(mode);
              idx_d   = 2'd0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge
    // values of the others, independent of statement order.
    if (reset) begin
      state_q    <= IDLE;
      // NOTE: the word buffer is cleared as well; it costs little and keeps
      // the datapath free of X after reset even though IDLE masks out_data.
      hold_q     <= 32'h0;
      nb_q       <= 2'd0;
      idx_q      <= 2'd0;
      word_cnt_q <= '0;
      mode_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      nb_q       <= nb_d;
      idx_q      <= idx_d;
      word_cnt_q <= word_cnt_d;
      mode_err_q <= mode_err_d;
    end
  end

  assign busy     = (state_q == SEND);
  assign mode_err = mode_err_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_width_conv_sched.sv
// Directed bench for width_conv_sched: a cycle-by-cycle vector table plus
// hand-written sequences for the mid-word mode switch and counter saturation.
module tb_width_conv_sched;

  localparam int CNT_W = 4;  // small so saturation is reachable quickly

  typedef struct {
    logic        rst;
    logic [1:0]  mode;
    logic [31:0] din;
    logic        iv;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [7:0]  e_od;
    logic        e_sof;
    logic        e_eof;
    logic        e_busy;
    logic        e_err;
    logic [15:0] e_cnt;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       mode;
  logic [31:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sof;
  logic             out_eof;
  logic             busy;
  logic             mode_err;
  logic [CNT_W-1:0] word_cnt;

  int errors = 0;
  int checks = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  width_conv_sched #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .busy      (busy),
    .mode_err  (mode_err),
    .word_cnt  (word_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [1:0] m, input logic [31:0] din,
                              input logic iv, input logic ordy, input logic e_ir,
                              input logic e_ov, input logic [7:0] e_od, input logic e_sof,
                              input logic e_eof, input logic e_busy, input logic e_err,
                              input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.mode = m; v.din = din; v.iv = iv; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_sof = e_sof; v.e_eof = e_eof;
    v.e_busy = e_busy; v.e_err = e_err; v.e_cnt = e_cnt;
    return v;
  endfunction

  // Drive one cycle's inputs just after the falling edge, compare outputs
  // mid-cycle, then let the rising edge commit.
  task automatic apply(input vec_t v, input string tag);
    reset     = v.rst;
    mode      = v.mode;
    in_data   = v.din;
    in_valid  = v.iv;
    out_ready = v.ordy;
    #1;
    check({tag, " in_ready"},  {31'b0, in_ready},  {31'b0, v.e_ir});
    check({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, v.e_ov});
    check({tag, " out_data"},  {24'b0, out_data},  {24'b0, v.e_od});
    check({tag, " out_sof"},   {31'b0, out_sof},   {31'b0, v.e_sof});
    check({tag, " out_eof"},   {31'b0, out_eof},   {31'b0, v.e_eof});
    check({tag, " busy"},      {31'b0, busy},      {31'b0, v.e_busy});
    check({tag, " mode_err"},  {31'b0, mode_err},  {31'b0, v.e_err});
    check({tag, " word_cnt"},  {{(32-CNT_W){1'b0}}, word_cnt}, {16'b0, v.e_cnt});
    @(negedge clk);
  endtask

  task automatic drive(input logic rst, input logic [1:0] m, input logic [31:0] din,
                       input logic iv, input logic ordy);
    reset = rst; mode = m; in_data = din; in_valid = iv; out_ready = ordy;
    @(negedge clk);
  endtask

  initial begin
    // ---- vector table: cols rst,mode,din,iv,ordy | ir,ov,od,sof,eof,busy,err,cnt
    // reset state
    vecs.push_back(mk(1, 2'd0, 32'h0, 0, 1,  0, 0, 8'h00, 0, 0, 0, 0, 0));
    // mode 10, A1B2C3D4
    vecs.push_back(mk(0, 2'd2, 32'hA1B2C3D4, 1, 1,  1, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'd2, 32'hA1B2C3D4, 0, 1,  0, 1, 8'hD4, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 2'd2, 32'h0, 0, 1,  0, 1, 8'hC3, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 2'd2, 32'h0, 0, 1,  0, 1, 8'hB2, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 2'd2, 32'h0, 0, 1,  1, 1, 8'hA1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 2'd2, 32'h0, 0, 1,  1, 0, 8'h00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 2'd0, 32'h0, 0, 1,  0, 0, 8'h00, 0, 0, 0, 0, 1));
    // back-to-back: mode 01 1234BEEF then mode 00 FFFFFF5A
    vecs.push_back(mk(0, 2'd1, 32'h1234BEEF, 1, 1,  1, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'd0, 32'hFFFFFF5A, 1, 1,  0, 1, 8'hEF, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 2'd0, 32'hFFFFFF5A, 1, 1,  1, 1, 8'hBE, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 2'd0, 32'h0, 0, 1,  1, 1, 8'h5A, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 2'd0, 32'h0, 0, 1,  1, 0, 8'h00, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 2'd0, 32'h0, 0, 1,  0, 0, 8'h00, 0, 0, 0, 0, 2));
    // backpressure: 01020304, stall 3 cycles on 03, stall once on last byte
    vecs.push_back(mk(0, 2'd2, 32'h01020304, 1, 1,  1, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'd2, 32'h0, 0, 1,  0, 1, 8'h04, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 2'd2, 32'h0, 0, 0,  0, 1, 8'h03, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 2'd2, 32'h0, 0, 0,  0, 1, 8'h03, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 2'd2, 32'h0, 0, 0,  0, 1, 8'h03, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 2'd2, 32'h0, 0, 1,  0, 1, 8'h03, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 2'd2, 32'h0, 0, 1,  0, 1, 8'h02, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 2'd2, 32'h0, 1, 0,  0, 1, 8'h01, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 2'd2, 32'h0, 0, 1,  1, 1, 8'h01, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 2'd2, 32'h0, 0, 1,  1, 0, 8'h00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 2'd0, 32'h0, 0, 1,  0, 0, 8'h00, 0, 0, 0, 0, 1));
    // illegal mode: sticky error, nothing accepted
    vecs.push_back(mk(0, 2'd3, 32'hDEADBEEF, 1, 1,  0, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'd3, 32'hDEADBEEF, 1, 1,  0, 0, 8'h00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 2'd0, 32'h0, 0, 1,  1, 0, 8'h00, 0, 0, 0, 1, 0));
    // word in flight completes while mode goes illegal
    vecs.push_back(mk(0, 2'd1, 32'h0000ABCD, 1, 1,  1, 0, 8'h00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 2'd3, 32'h0, 1, 1,  0, 1, 8'hCD, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 2'd3, 32'h0, 1, 1,  0, 1, 8'hAB, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 2'd3, 32'h0, 0, 1,  0, 0, 8'h00, 0, 0, 0, 1, 1));
    // reset mid-word clears error and count, then a fresh word from byte 0
    vecs.push_back(mk(0, 2'd2, 32'h11223344, 1, 1,  1, 0, 8'h00, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 2'd2, 32'h0, 0, 1,  0, 1, 8'h44, 1, 0, 1, 1, 1));
    vecs.push_back(mk(0, 2'd2, 32'h0, 0, 1,  0, 1, 8'h33, 0, 0, 1, 1, 1));
    vecs.push_back(mk(1, 2'd2, 32'h0, 0, 1,  0, 1, 8'h22, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 2'd2, 32'h55667788, 1, 1,  1, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'd2, 32'h0, 0, 1,  0, 1, 8'h88, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 2'd2, 32'h0, 0, 1,  0, 1, 8'h77, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 2'd2, 32'h0, 0, 1,  0, 1, 8'h66, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 2'd2, 32'h0, 0, 1,  1, 1, 8'h55, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 2'd2, 32'h0, 0, 1,  1, 0, 8'h00, 0, 0, 0, 0, 1));

    // power-up: one unchecked reset edge to leave the X state
    reset = 1'b1; mode = 2'd0; in_data = 32'h0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // ---- mode switch mid-word: mode changes to 00 after the first byte
    drive(1, 2'd0, 32'h0, 0, 1);
    apply(mk(0, 2'd2, 32'hCAFEF00D, 1, 1,  1, 0, 8'h00, 0, 0, 0, 0, 0), "msw0");
    apply(mk(0, 2'd2, 32'h0, 0, 1,  0, 1, 8'h0D, 1, 0, 1, 0, 0), "msw1");
    apply(mk(0, 2'd0, 32'h0, 0, 1,  0, 1, 8'hF0, 0, 0, 1, 0, 0), "msw2");
    apply(mk(0, 2'd0, 32'h0, 0, 1,  0, 1, 8'hFE, 0, 0, 1, 0, 0), "msw3");
    apply(mk(0, 2'd0, 32'h000000AB, 1, 1,  1, 1, 8'hCA, 0, 1, 1, 0, 0), "msw4");
    apply(mk(0, 2'd0, 32'h0, 0, 1,  1, 1, 8'hAB, 1, 1, 1, 0, 1), "msw5");
    apply(mk(0, 2'd0, 32'h0, 0, 1,  1, 0, 8'h00, 0, 0, 0, 0, 2), "msw6");

    // ---- counter saturation: 20 back-to-back single-byte words, 19 completed
    drive(1, 2'd0, 32'h0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      drive(0, 2'd0, 32'h0, 1, 1);
    end
    apply(mk(0, 2'd0, 32'h0, 0, 1,  1, 1, 8'h00, 1, 1, 1, 0, 15), "sat0");
    apply(mk(0, 2'd0, 32'h0, 0, 1,  1, 0, 8'h00, 0, 0, 0, 0, 15), "sat1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
